// File: rtl/acc_drain.sv
// Row-result collector: requantizes the accumulator sum, buffers it in a FIFO and drives stall back-pressure.
// Optional clamp-to-range saturation is enabled by defining ACC_DRAIN_SAT_EN.
module acc_drain #(
  parameter int DEPTH = 4,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [23:0]      acc_sum,
  output logic             stall,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             sat_flag,
  output logic             ovf_flag
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic signed [24:0] wide_t;

  // Half-LSB rounding constant; the sum cannot overflow 25 bits for a 24-bit input.
  localparam wide_t RND = (SHIFT > 0) ? (wide_t'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : wide_t'(0);

  logic             pend_q, pend_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [OUT_W-1:0] mem_q [DEPTH];

  wide_t            ext_s;
  wide_t            rnd_s;
  logic [OUT_W-1:0] push_val;
  logic             pop;
  logic             full;
  logic             push_en;
  logic             drop;
  logic [CNT_W:0]   occ;

`ifdef ACC_DRAIN_SAT_EN
  localparam wide_t MAX_V = wide_t'((longint'(1) << (OUT_W - 1)) - 1);
  localparam wide_t MIN_V = -MAX_V - wide_t'(1);

  logic sat_q, sat_d;
  logic clip;

  always_comb begin
    clip     = 1'b0;
    push_val = rnd_s[OUT_W-1:0];
    if (rnd_s > MAX_V) begin
      clip     = 1'b1;
      push_val = MAX_V[OUT_W-1:0];
    end else if (rnd_s < MIN_V) begin
      clip     = 1'b1;
      push_val = MIN_V[OUT_W-1:0];
    end
    sat_d = sat_q | (pend_q & clip);
  end

  always_ff @(posedge clk) begin
    if (reset) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`else
  logic unused_hi;

  // Two's-complement wrap: the bits above OUT_W are simply discarded.
  assign push_val  = rnd_s[OUT_W-1:0];
  assign unused_hi = ^rnd_s[24:OUT_W-1];
  assign sat_flag  = 1'b0;
`endif

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    ext_s    = {acc_sum[23], acc_sum};
    rnd_s    = (ext_s + RND) >>> SHIFT;

    pend_d   = in_valid & in_last;
    pop      = (count_q != '0) & out_ready;
    full     = (count_q == CNT_W'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push_en  = pend_q & (~full | pop);
    drop     = pend_q & full & ~pop;

    wr_ptr_d = wr_ptr_q + PTR_W'(push_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    unique case ({push_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d    = ovf_q | drop;

    occ      = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_q};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: the storage array is not reset; out_data is gated by out_valid so stale entries never show.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_val;
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign stall     = (occ >= (CNT_W + 1)'(DEPTH - 1));
  assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_acc_drain.sv
// Self-checking bench for acc_drain: queue-based scoreboard plus directed checks of the rounding,
// back-pressure, overflow and reset behaviour. Expectations follow ACC_DRAIN_SAT_EN when it is defined.
module tb_acc_drain;

  localparam int DEPTH = 4;
  localparam int OUT_W = 16;
  localparam int SHIFT = 8;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_last;
  logic [23:0]      acc_sum;
  logic             stall;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             sat_flag;
  logic             ovf_flag;

  acc_drain #(.DEPTH(DEPTH), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .acc_sum   (acc_sum),
    .stall     (stall),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_flag  (sat_flag),
    .ovf_flag  (ovf_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference requantizer written with plain integer arithmetic.
  function automatic logic [OUT_W-1:0] model_q(input logic [23:0] s, output bit clip);
    longint e;
    longint r;
    longint max_v;
    longint min_v;
    e     = longint'($signed(s));
    r     = e;
    if (SHIFT > 0) r = (e + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    max_v = (longint'(1) << (OUT_W - 1)) - 1;
    min_v = -max_v - 1;
    clip  = 1'b0;
`ifdef ACC_DRAIN_SAT_EN
    if (r > max_v) begin r = max_v; clip = 1'b1; end
    else if (r < min_v) begin r = min_v; clip = 1'b1; end
`else
    if (r > max_v || r < min_v) clip = 1'b0;
`endif
    return r[OUT_W-1:0];
  endfunction

  logic [OUT_W-1:0] sb_q[$];
  bit               pend_m;
  bit               sat_m;
  bit               ovf_m;
  bit               live;

  always @(posedge clk) begin : model
    bit               clip;
    bit               pop;
    logic [OUT_W-1:0] v;
    if (reset) begin
      sb_q.delete();
      pend_m <= 1'b0;
      sat_m  <= 1'b0;
      ovf_m  <= 1'b0;
      live   <= 1'b1;
    end else if (live) begin
      pop = (sb_q.size() != 0) && (out_ready === 1'b1);
      if (pop) void'(sb_q.pop_front());
      if (pend_m) begin
        v = model_q(acc_sum, clip);
        if (clip) sat_m <= 1'b1;
        if (sb_q.size() < DEPTH) sb_q.push_back(v);
        else ovf_m <= 1'b1;
      end
      pend_m <= in_valid & in_last;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("valid", out_valid, sb_q.size() != 0);
      if (sb_q.size() != 0) check("data", out_data, sb_q[0]);
      check("stall", stall, (sb_q.size() + pend_m) >= DEPTH - 1);
      check("ovf", ovf_flag, ovf_m);
      check("sat", sat_flag, sat_m);
    end
  end

  logic [23:0] burst [8];

  // Issues n consecutive in_last beats; each row's sum appears on acc_sum the cycle after its beat.
  task automatic send_burst(input int n);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      in_valid = (i < n);
      in_last  = (i < n);
      acc_sum  = (i > 0) ? burst[i-1] : 24'($urandom);
    end
  endtask

  task automatic single_row(input string tag, input logic [23:0] sum, input logic [OUT_W-1:0] exp);
    burst[0] = sum;
    send_burst(1);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1'b1);
    check(tag, out_data, exp);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && out_valid; i++) @(negedge clk);
    check("drain", out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    acc_sum   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_stall", stall, 1'b0);
    check("rst_sat", sat_flag, 1'b0);
    check("rst_ovf", ovf_flag, 1'b0);

    single_row("round_pos", 24'h000180, 16'h0002);
    single_row("round_neg1", 24'hFFFE80, 16'hFFFF);
    single_row("round_neg0", 24'hFFFF80, 16'h0000);
`ifdef ACC_DRAIN_SAT_EN
    single_row("sat_hi", 24'h7FFFFF, 16'h7FFF);
    @(negedge clk);
    check("sat_hi_flag", sat_flag, 1'b1);
`else
    single_row("wrap_hi", 24'h7FFFFF, 16'h8000);
    @(negedge clk);
    check("wrap_hi_flag", sat_flag, 1'b0);
`endif
    single_row("min_neg", 24'h800000, 16'h8000);

    // in_last without in_valid must not produce a result.
    @(negedge clk);
    in_last = 1'b1;
    @(negedge clk);
    in_last = 1'b0;
    repeat (2) @(negedge clk);
    check("last_only", out_valid, 1'b0);

    // Back-pressure: four rows with the consumer stalled, then released.
    drain();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) burst[k] = 24'(256 * (k + 1));
    send_burst(4);
    repeat (2) @(negedge clk);
    check("bp_stall", stall, 1'b1);
    check("bp_ovf", ovf_flag, 1'b0);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("bp_order", out_data, 32'(k));
      @(negedge clk);
    end
    check("bp_empty", out_valid, 1'b0);

    // Fill, then push and pop together at count==DEPTH, then overflow.
    out_ready = 1'b0;
    send_burst(4);
    @(negedge clk);
    in_valid = 1'b1;
    in_last  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    acc_sum   = 24'd1280;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("pp_ovf", ovf_flag, 1'b0);
    check("pp_head", out_data, 16'd2);
    check("pp_full", stall, 1'b1);
    single_row("ovf_head", 24'd1536, 16'd2);
    check("ovf_set", ovf_flag, 1'b1);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check("ovf_order", out_data, 32'(k));
      @(negedge clk);
    end
    check("ovf_empty", out_valid, 1'b0);

    // Reset with two buffered results and one pending; a beat in the reset cycle is ignored.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) burst[k] = 24'(256 * (k + 7));
    send_burst(3);
    in_valid = 1'b1;
    in_last  = 1'b1;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("mid_valid", out_valid, 1'b0);
    check("mid_stall", stall, 1'b0);
    check("mid_ovf", ovf_flag, 1'b0);
    check("mid_sat", sat_flag, 1'b0);
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("mid_stale", out_valid, 1'b0);
    end

    // Random traffic that honours stall; the scoreboard checks every cycle.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_last   = !stall && ($urandom_range(0, 1) == 1);
      acc_sum   = 24'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(negedge clk);
    drain();
    check("rand_ovf", ovf_flag, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
